// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared definitions for the ADC capture buffer: default geometry, the
// capture FSM state encoding and the mid-scale threshold used by the optional
// zero-crossing trigger (ADC_CAPTURE_ZERO_TRIG_EN).
// -----------------------------------------------------------------------------
package adc_capture_pkg;

    localparam int DEF_NCH        = 6;   // analog channels (3 V + 3 I)
    localparam int DEF_DATA_W     = 8;   // bits per channel sample
    localparam int DEF_DEPTH_LOG2 = 12;  // 4096 records

    localparam logic [7:0] MID_SCALE = 8'd128;

    typedef enum logic [1:0] {
        S_WAIT_TRIG = 2'd0,
        S_FILL      = 2'd1,
        S_FULL      = 2'd2
    } state_t;

endpackage : adc_capture_pkg

// File: rtl/adc_capture_buffer_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Simple dual-port record memory: one synchronous write port, one registered
// synchronous read port. The array has no reset so it maps onto block RAM;
// only the read data register is cleared by reset.
//
// Ports:
//   i_clk      - clock
//   i_reset    - synchronous active-high reset (read data register only)
//   i_we       - write enable
//   i_wr_addr  - write record index
//   i_wr_data  - write record
//   i_rd_addr  - read record index (sampled every clock)
//   o_rd_data  - registered read record, one cycle after i_rd_addr
// -----------------------------------------------------------------------------
module capture_ram
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_DEPTH_LOG2,
    parameter int DATA_W = DEF_NCH * DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write on an address collision; the top never trusts the
    // read data while writes are still happening.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : capture_ram

// File: rtl/adc_capture_buffer.sv
// -----------------------------------------------------------------------------
// adc_capture_buffer
// Captures simultaneous NCH x DATA_W samples into a 2^DEPTH_LOG2 record
// buffer. When the last record is written the buffer freezes and
// writing_finish_flag rises; the processor then reads any record back.
//
// Optional feature macro: ADC_CAPTURE_ZERO_TRIG_EN
//   defined   - reset/rearm enter S_WAIT_TRIG; capture starts on the first
//               rising mid-scale crossing of channel1, that sample goes to
//               address 0.
//   undefined - reset/rearm enter S_FILL directly (free-running capture).
//
// Ports:
//   clk                 - system clock
//   reset               - synchronous active-high reset
//   sample_valid        - one-cycle sample strobe
//   sample_data         - packed record, channel k at [k*DATA_W +: DATA_W]
//   rearm               - one-cycle pulse starting a new capture
//   read_address        - record index driven by the processor
//   channel_analog      - read-back record, same packing as sample_data
//   read_new_sample     - channel_analog valid for read_address (FULL only)
//   writing_finish_flag - buffer full and frozen
//   o_dbg_state         - current FSM state
//   o_dbg_wr_ptr        - current write pointer
//
// Read handshake: read_new_sample is a level, not a strobe. It is high only
// when the record on channel_analog was fetched from an address equal to the
// read_address currently held, and the buffer is frozen. Any address change
// drops it for at least one cycle; holding the address for two edges raises it.
// -----------------------------------------------------------------------------
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [NCH*DATA_W-1:0]   sample_data,
    input  logic                    rearm,
    input  logic [DEPTH_LOG2-1:0]   read_address,
    output logic [NCH*DATA_W-1:0]   channel_analog,
    output logic                    read_new_sample,
    output logic                    writing_finish_flag,
    output state_t                  o_dbg_state,
    output logic [DEPTH_LOG2-1:0]   o_dbg_wr_ptr
);

    localparam int W = NCH * DATA_W;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;
    localparam logic [DEPTH_LOG2-1:0] ONE       = 1;

`ifdef ADC_CAPTURE_ZERO_TRIG_EN
    localparam state_t START_STATE = S_WAIT_TRIG;
`else
    localparam state_t START_STATE = S_FILL;
`endif

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   w_wr_ptr_next;
    logic                    w_we;
    logic [DEPTH_LOG2-1:0]   w_wr_addr;
    logic [DEPTH_LOG2-1:0]   r_rd_addr;
    logic                    r_rd_match;
    logic [W-1:0]            w_rd_data;

`ifdef ADC_CAPTURE_ZERO_TRIG_EN
    logic [DATA_W-1:0]       w_ch1;
    logic                    r_prev_below;
    logic                    w_crossing;

    assign w_ch1      = sample_data[DATA_W-1:0];
    assign w_crossing = (w_ch1 >= MID_SCALE) && r_prev_below;

    // Tracks whether the last valid channel1 value was below mid-scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_below <= 1'b0;
        end else if (sample_valid) begin
            r_prev_below <= (w_ch1 < MID_SCALE);
        end
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= START_STATE;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= w_wr_ptr_next;
        end
    end

    // ---------------- FSM: next state and write control ----------------
    // rearm takes priority over any strobe in the same cycle, so a strobe
    // coinciding with rearm is not written.
    always_comb begin
        w_state_next  = r_state;
        w_wr_ptr_next = r_wr_ptr;
        w_we          = 1'b0;
        w_wr_addr     = r_wr_ptr;
        case (r_state)
            S_FILL: begin
                if (rearm) begin
                    w_state_next  = START_STATE;
                    w_wr_ptr_next = '0;
                end else if (sample_valid) begin
                    w_we          = 1'b1;
                    w_wr_ptr_next = r_wr_ptr + ONE;  // wraps to 0 after the last record
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (rearm) begin
                    w_state_next  = START_STATE;
                    w_wr_ptr_next = '0;
                end
            end
`ifdef ADC_CAPTURE_ZERO_TRIG_EN
            S_WAIT_TRIG: begin
                if (rearm) begin
                    w_wr_ptr_next = '0;
                end else if (sample_valid && w_crossing) begin
                    w_we          = 1'b1;
                    w_wr_addr     = '0;
                    w_wr_ptr_next = ONE;
                    w_state_next  = S_FILL;
                end
            end
`endif
            default: begin
                w_state_next  = START_STATE;
                w_wr_ptr_next = '0;
            end
        endcase
    end

    // ---------------- Read path ----------------
    // r_rd_match is set when the address registered at this edge equals the
    // one already held, i.e. the RAM read launched at this edge used the
    // address the processor is still presenting. Qualifying with S_FULL
    // before the edge keeps the record fetched during the final write out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr  <= '0;
            r_rd_match <= 1'b0;
        end else begin
            r_rd_addr  <= read_address;
            r_rd_match <= (read_address == r_rd_addr) && (r_state == S_FULL);
        end
    end

    capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (W)
    ) u_ram (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (sample_data),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign channel_analog      = w_rd_data;
    assign read_new_sample     = r_rd_match && (r_state == S_FULL);
    assign writing_finish_flag = (r_state == S_FULL);
    assign o_dbg_state         = r_state;
    assign o_dbg_wr_ptr        = r_wr_ptr;

endmodule : adc_capture_buffer

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;
    import adc_capture_pkg::*;

    localparam int NCH   = 6;
    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int W     = NCH * DW;
    localparam int DEPTH = 1 << AW;
`ifdef ADC_CAPTURE_ZERO_TRIG_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [W-1:0]  sample_data;
    logic          rearm;
    logic [AW-1:0] read_address;
    logic [W-1:0]  channel_analog;
    logic          read_new_sample;
    logic          writing_finish_flag;
    state_t        dbg_state;
    logic [AW-1:0] dbg_wr_ptr;

    always #5 clk = ~clk;

    adc_capture_buffer dut (
        .clk                 (clk),
        .reset               (reset),
        .sample_valid        (sample_valid),
        .sample_data         (sample_data),
        .rearm               (rearm),
        .read_address        (read_address),
        .channel_analog      (channel_analog),
        .read_new_sample     (read_new_sample),
        .writing_finish_flag (writing_finish_flag),
        .o_dbg_state         (dbg_state),
        .o_dbg_wr_ptr        (dbg_wr_ptr)
    );

    // ---------------- scoreboard state ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic         rd_pending = 1'b0;

    // ---------------- reference model ----------------
    // Buffer as a plain array plus a write count and a phase:
    // 0 = waiting for trigger, 1 = filling, 2 = frozen.
    logic [W-1:0] model_mem [DEPTH];
    int           model_ptr;
    int           model_phase;
    bit           model_prev_below;

    task automatic model_reset();
        model_ptr        = 0;
        model_phase      = TRIG_EN ? 0 : 1;
        model_prev_below = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] d, input logic rr);
        if (rr) begin
            model_ptr   = 0;
            model_phase = TRIG_EN ? 0 : 1;
        end else if (model_phase == 1) begin
            model_mem[model_ptr] = d;
            model_ptr++;
            if (model_ptr == DEPTH) begin
                model_ptr   = 0;
                model_phase = 2;
            end
        end else if (model_phase == 0) begin
            if (int'(d[7:0]) >= 128 && model_prev_below) begin
                model_mem[0] = d;
                model_ptr    = 1;
                model_phase  = 1;
            end
        end
        if (TRIG_EN) model_prev_below = (int'(d[7:0]) < 128);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rd_pending && read_new_sample) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_scoreboard: got %h expected <empty queue>", channel_analog);
            end else begin
                e = exp_q.pop_front();
                check("read_data", channel_analog, e);
            end
            rd_pending = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] d, input logic rr);
        sample_valid = 1'b1;
        sample_data  = d;
        rearm        = rr;
        model_step(d, rr);
        tick();
        sample_valid = 1'b0;
        rearm        = 1'b0;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        model_step('0, 1'b1);
        tick();
        rearm = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_rec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {6{b}};
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) strobe(rand_rec(), 1'b0);
    endtask

    task automatic read_wait();
        for (int i = 0; i < 8 && rd_pending; i++) tick();
        if (rd_pending) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_timeout: got read_new_sample=0 expected 1 within 8 cycles");
            rd_pending = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic read_exp(input logic [AW-1:0] a, input logic [W-1:0] e);
        exp_q.push_back(e);
        read_address = a;
        tick();
        rd_pending = 1'b1;
        read_wait();
    endtask

    task automatic read_check(input logic [AW-1:0] a);
        read_exp(a, model_mem[a]);
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) read_check(AW'($urandom_range(0, DEPTH - 1)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flag"}, writing_finish_flag, '0);
        check({tag, "_rns"},  read_new_sample, '0);
        check({tag, "_data"}, channel_analog, '0);
        check({tag, "_ptr"},  dbg_wr_ptr, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        rearm        = 1'b0;
        read_address = '0;
        model_reset();
        tick();
        tick();
        check_reset_outputs("reset");
        check("reset_state", dbg_state, TRIG_EN ? S_WAIT_TRIG : S_FILL);
        reset = 1'b0;

`ifdef ADC_CAPTURE_ZERO_TRIG_EN
        // Rising mid-scale crossing on channel1 starts the capture.
        strobe(rep(8'd100), 1'b0);
        check("trig_100_ptr", dbg_wr_ptr, '0);
        strobe(rep(8'd120), 1'b0);
        check("trig_120_ptr", dbg_wr_ptr, '0);
        check("trig_wait_state", dbg_state, S_WAIT_TRIG);
        strobe(rep(8'd140), 1'b0);
        check("trig_fill_state", dbg_state, S_FILL);
        strobe(rep(8'd160), 1'b0);
        check("trig_ptr_after", dbg_wr_ptr, 2);
        fill_rand(DEPTH - 2);
        check("trig_full_flag", writing_finish_flag, 1'b1);
        read_exp(12'h001, rep(8'd160));
        read_exp(12'h000, rep(8'd140));
        random_reads(10);
`else
        // Full capture with record i = {6{i[7:0]}}.
        for (int i = 0; i < DEPTH; i++) begin
            strobe(rep(8'(i)), 1'b0);
            if (i == DEPTH - 2) check("flag_before_last", writing_finish_flag, '0);
        end
        check("flag_after_last", writing_finish_flag, 1'b1);
        check("ptr_after_full", dbg_wr_ptr, '0);

        // Read 0x123 with explicit latency checks.
        exp_q.push_back(rep(8'h23));
        read_address = 12'h123;
        tick();
        check("rns_after_change", read_new_sample, '0);
        rd_pending = 1'b1;
        tick();
        check("rns_two_cycles", read_new_sample, 1'b1);
        read_wait();

        // Strobes while frozen must not alter the buffer.
        fill_rand(5);
        check("full_flag_hold", writing_finish_flag, 1'b1);
        read_check(12'h124);
        read_exp(12'h123, rep(8'h23));
        random_reads(10);

        // Address changing every cycle keeps read_new_sample low.
        for (int k = 0; k < 8; k++) begin
            read_address = read_address + AW'(1 + $urandom_range(0, 100));
            tick();
            check("rns_moving_addr", read_new_sample, '0);
        end
        tick();
        check("rns_settled", read_new_sample, 1'b1);
        check("data_settled", channel_analog, model_mem[read_address]);

        // rearm from FULL, then rearm colliding with the last write.
        do_rearm();
        check("rearm_flag", writing_finish_flag, '0);
        check("rearm_state", dbg_state, S_FILL);
        check("rearm_ptr", dbg_wr_ptr, '0);
        check("rearm_rns", read_new_sample, '0);
        fill_rand(DEPTH - 1);
        strobe(rand_rec(), 1'b1);
        check("collide_flag", writing_finish_flag, '0);
        check("collide_ptr", dbg_wr_ptr, '0);
        strobe(rand_rec(), 1'b0);
        check("collide_next_ptr", dbg_wr_ptr, 1);
        fill_rand(DEPTH - 1);
        check("collide_full_flag", writing_finish_flag, 1'b1);
        read_check(12'h000);
        read_check(12'hFFF);
        random_reads(6);

        // Reset in the middle of a capture.
        do_rearm();
        fill_rand(2000);
        reset = 1'b1;
        model_reset();
        tick();
        check_reset_outputs("midreset");
        check("midreset_state", dbg_state, S_FILL);
        reset = 1'b0;
        fill_rand(DEPTH);
        check("post_reset_full", writing_finish_flag, 1'b1);
        read_check(12'h000);
        read_check(12'hFFF);
        random_reads(8);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adc_capture_buffer

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Acquisition stage directly upstream of the Nios II controlled section. It captures simultaneous 8-bit samples from the six analog channels (3 voltages, 3 currents) into a 4096-deep on-chip buffer. When the buffer is full it raises `writing_finish_flag` and freezes the contents. The processor then reads back any record by driving `read_address` and waiting for `read_new_sample`.

## Interface
Parameters:
- `NCH`, 6: number of channels.
- `DATA_W`, 8: bits per channel sample.
- `DEPTH_LOG2`, 12: buffer depth is 2^DEPTH_LOG2 records; this must match the width of `read_address`.

Ports (one clock; reset is synchronous and active-high):
- `clk` — in — 1 — system clock, shared with the Nios II section.
- `reset` — in — 1 — synchronous, active-high.
- `sample_valid` — in — 1 — one-cycle strobe from the ADC interface.
- `sample_data` — in — NCH*DATA_W — channel k is bits [k*8+7 : k*8]; channel1 is k=0.
- `rearm` — in — 1 — one-cycle pulse that starts a new capture.
- `read_address` — in — DEPTH_LOG2 — record index, driven by the processor.
- `channel_analog` — out — NCH*DATA_W — the read-back record; same packing as `sample_data`; slice k feeds `channel(k+1)_analog_export`.
- `read_new_sample` — out — 1 — high means `channel_analog` is valid for the current `read_address`.
- `writing_finish_flag` — out — 1 — buffer full and frozen.

## Operation
States:
- FILL:
  - Each `sample_valid` writes `sample_data` to `wr_ptr`, then increments `wr_ptr`.
  - The write at `wr_ptr` = 2^DEPTH_LOG2−1 moves the block to FULL in the next cycle. `wr_ptr` wraps to 0.
- FULL:
  - `sample_valid` is ignored; the buffer contents are never modified.
  - `writing_finish_flag` = 1.
  - `rearm` moves the block to FILL with `wr_ptr` = 0 and `writing_finish_flag` = 0 in the next cycle.
- WAIT_TRIG: present only with the configuration macro (see Configuration).

Read port:
- Active in every state.
- `channel_analog` always shows the RAM contents at the registered address.
- `read_new_sample` is forced to 0 outside FULL.

Boundary rules:
- `rearm` during FILL restarts the capture: `wr_ptr` = 0, and already-written records are treated as stale.
- `rearm` in the same cycle as the final write: `rearm` wins; the block stays in FILL with `wr_ptr` = 0.
- `reset` mid-capture: returns to the reset state regardless of the current state; RAM contents are not cleared.
- A `sample_valid` with no `rearm` pending is never dropped during FILL.

Reset values:
- state = FILL, or WAIT_TRIG when the macro is defined.
- `wr_ptr` = 0.
- `writing_finish_flag` = 0.
- `read_new_sample` = 0.
- `channel_analog` = 0.

## Timing
- Write: the sample is stored in the RAM at the clock edge of the `sample_valid` cycle.
- Read latency is 2 cycles: `read_address` is registered at edge N, the RAM output is registered at edge N+1, and `channel_analog` is valid after edge N+1.
- `read_new_sample`:
  - Drops to 0 in the cycle after a change in `read_address` is registered.
  - Rises 2 cycles after the address becomes stable.
  - Stays high while the address is unchanged and the state is FULL.
- `writing_finish_flag` rises 1 cycle after the final write edge. It falls 1 cycle after `rearm` or `reset`.
- A read of address A in FULL returns the sample that was written at A. The first sample of the capture is at address 0.

## Configuration
- `ADC_CAPTURE_ZERO_TRIG_EN`:
  - Defined: adds the WAIT_TRIG state. Reset and `rearm` enter WAIT_TRIG. The block moves to FILL on the first `sample_valid` whose channel1 value is ≥ 128 while the previous valid channel1 value was < 128 (rising mid-scale crossing). That triggering sample is written to address 0. `sample_valid` strobes without a crossing are discarded.
  - Undefined: reset and `rearm` enter FILL directly, and the capture is free-running.

## Structure
- Package `adc_capture_pkg`:
  - `NCH`, `DATA_W` and `DEPTH_LOG2` defaults.
  - A state enum `{S_WAIT_TRIG, S_FILL, S_FULL}`.
  - `MID_SCALE` = 8'd128.
- Sub-module `capture_ram`:
  - Simple dual-port memory, 2^DEPTH_LOG2 × NCH*DATA_W bits.
  - Synchronous write and registered synchronous read.
  - No reset on the array, so it can be inferred as block RAM.
- Top level contains the FSM, `wr_ptr`, the address register and the valid pipeline.

## Test plan
- Reset, then 4096 `sample_valid` strobes carrying record i = {6{i[7:0]}} → `writing_finish_flag` = 1 exactly 1 cycle after the 4096th strobe; `wr_ptr` = 0.
- In FULL, set `read_address` = 0x123 → `read_new_sample` is 0, then 1 two cycles later; `channel_analog` = {6{8'h23}}. Further `sample_valid` strobes leave that record unchanged.
- `rearm` coinciding with the 4096th strobe → `writing_finish_flag` stays 0; the next strobe is written to address 0.
- `reset` asserted after 2000 samples → outputs return to their reset values; a full 4096-sample capture follows correctly.
- Change `read_address` every cycle in FULL → `read_new_sample` stays 0 until the address is held for 2 cycles.
- With `ADC_CAPTURE_ZERO_TRIG_EN` defined, channel1 sequence 100, 120, 140, … → the record at address 0 has channel1 = 140; the strobes carrying 100 and 120 are not stored.
